// File: rtl/imm_seq_pkg.sv
// Shared types for the immediate-generation sequencer: extender class codes,
// LEGv8 opcode match patterns and the decode-result struct.
package imm_seq_pkg;

    typedef enum logic [2:0] {
        IMM_CLS_I   = 3'b000,
        IMM_CLS_D   = 3'b001,
        IMM_CLS_B   = 3'b010,
        IMM_CLS_CBZ = 3'b011,
        IMM_CLS_MOV = 3'b100
    } imm_cls_e;

    localparam int IMM_RD_W = 5;

    typedef struct packed {
        imm_cls_e              cls;
        logic                  keep;
        logic                  illegal;
        logic [IMM_RD_W-1:0]   rd;
    } imm_dec_t;

    // Patterns on instr[31:21]; a cleared mask bit is a don't-care.
    localparam logic [10:0] OPC_ADDI_VAL = 11'b10010001000;
    localparam logic [10:0] OPC_ADDI_MSK = 11'b11111101110;
    localparam logic [10:0] OPC_LDST_VAL = 11'b11111000000;
    localparam logic [10:0] OPC_LDST_MSK = 11'b11111111101;
    localparam logic [10:0] OPC_B_VAL    = 11'b00010100000;
    localparam logic [10:0] OPC_B_MSK    = 11'b11111100000;
    localparam logic [10:0] OPC_CBZ_VAL  = 11'b10110100000;
    localparam logic [10:0] OPC_CBZ_MSK  = 11'b11111110000;
    localparam logic [10:0] OPC_MOVZ_VAL = 11'b11010010100;
    localparam logic [10:0] OPC_MOVK_VAL = 11'b11110010100;
    localparam logic [10:0] OPC_MOV_MSK  = 11'b11111111100;

    function automatic logic opc_match(input logic [10:0] opc,
                                       input logic [10:0] val,
                                       input logic [10:0] msk);
        return (opc & msk) == val;
    endfunction

endpackage

// File: rtl/imm_opcode_decoder.sv
// Combinational opcode classifier: maps instr[31:21] (plus Rd) onto the
// extender class, the MOVK keep flag and the illegal flag.
module imm_opcode_decoder
    import imm_seq_pkg::*;
(
    input  logic [10:0]         i_opcode,
    input  logic [IMM_RD_W-1:0] i_rd,
    output imm_dec_t            o_dec
);

    always_comb begin
        o_dec         = '0;
        o_dec.cls     = IMM_CLS_I;
        o_dec.rd      = i_rd;
        if (opc_match(i_opcode, OPC_ADDI_VAL, OPC_ADDI_MSK)) begin
            o_dec.cls = IMM_CLS_I;
        end else if (opc_match(i_opcode, OPC_LDST_VAL, OPC_LDST_MSK)) begin
            o_dec.cls = IMM_CLS_D;
        end else if (opc_match(i_opcode, OPC_B_VAL, OPC_B_MSK)) begin
            o_dec.cls = IMM_CLS_B;
        end else if (opc_match(i_opcode, OPC_CBZ_VAL, OPC_CBZ_MSK)) begin
            o_dec.cls = IMM_CLS_CBZ;
        end else if (opc_match(i_opcode, OPC_MOVZ_VAL, OPC_MOV_MSK)) begin
            o_dec.cls = IMM_CLS_MOV;
        end else if (opc_match(i_opcode, OPC_MOVK_VAL, OPC_MOV_MSK)) begin
            o_dec.cls  = IMM_CLS_MOV;
            o_dec.keep = 1'b1;
        end else begin
            o_dec.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/imm_sign_extender.sv
// LEGv8 immediate sign-extender: selects and extends the immediate field of
// Imm26 according to the 3-bit control code (MOV shifts by 16*hw).
module imm_sign_extender (
    input  logic [25:0] i_imm26,
    input  logic [2:0]  i_ctrl,
    output logic [63:0] o_bus_imm
);

    // NOTE: default assigned first so every path drives the output and no latch is inferred.
    always_comb begin
        o_bus_imm = '0;
        case (i_ctrl)
            3'b000:  o_bus_imm = {{52{i_imm26[21]}}, i_imm26[21:10]};
            3'b001:  o_bus_imm = {{55{i_imm26[20]}}, i_imm26[20:12]};
            3'b010:  o_bus_imm = {{38{i_imm26[25]}}, i_imm26[25:0]};
            3'b011:  o_bus_imm = {{45{i_imm26[23]}}, i_imm26[23:5]};
            3'b100:  o_bus_imm = {48'b0, i_imm26[20:5]} << {i_imm26[22:21], 4'b0000};
            default: o_bus_imm = '0;
        endcase
    end

endmodule

// File: rtl/imm_gen_sequencer.sv
// Two-stage valid/ready sequencer around the LEGv8 sign-extender with a
// MOVZ/MOVK wide-constant accumulator. Optional counters under IMM_STATS_EN.
module imm_gen_sequencer
    import imm_seq_pkg::*;
#(
    parameter int ACC_TAG_W = 5,
    parameter int STAT_W    = 16
) (
    input  logic              CLK,
    input  logic              resetl,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [63:0]       out_imm,
    output logic [2:0]        out_class,
    output logic              out_illegal,
    output logic [STAT_W-1:0] stat_ext_cnt,
    output logic [STAT_W-1:0] stat_ill_cnt
);

    logic                 r_run;
    logic                 r_s1_valid;
    logic [25:0]          r_s1_imm26;
    imm_dec_t             r_s1_dec;
    logic                 r_out_valid;
    logic [63:0]          r_out_imm;
    logic [2:0]           r_out_cls;
    logic                 r_out_ill;
    logic [63:0]          r_acc;
    logic [ACC_TAG_W-1:0] r_acc_tag;
    logic                 r_acc_live;

    imm_dec_t             w_dec;
    logic [63:0]          w_ext;
    logic [63:0]          w_result;
    logic [63:0]          w_keep_mask;
    logic [ACC_TAG_W-1:0] w_rd_tag;
    logic                 w_tag_hit;
    logic                 w_is_mov;
    logic                 w_s2_adv;
    logic                 w_s1_adv;
    logic                 w_accept;
    imm_cls_e             w_out_cls;

    imm_opcode_decoder u_dec (
        .i_opcode (in_instr[31:21]),
        .i_rd     (in_instr[4:0]),
        .o_dec    (w_dec)
    );

    imm_sign_extender u_ext (
        .i_imm26   (r_s1_imm26),
        .i_ctrl    (r_s1_dec.cls),
        .o_bus_imm (w_ext)
    );

    // in_ready depends combinationally on out_ready so a full pipe can accept
    // and deliver in the same cycle.
    assign w_s2_adv = out_ready || !r_out_valid;
    assign w_s1_adv = r_s1_valid && w_s2_adv;
    assign in_ready = r_run && (!r_s1_valid || w_s2_adv);
    assign w_accept = in_valid && in_ready;

    assign w_rd_tag    = ACC_TAG_W'(r_s1_dec.rd);
    assign w_tag_hit   = r_acc_live && (r_acc_tag == w_rd_tag);
    assign w_is_mov    = !r_s1_dec.illegal && (r_s1_dec.cls == IMM_CLS_MOV);
    assign w_keep_mask = ~(64'hFFFF << {r_s1_imm26[22:21], 4'b0000});
    assign w_out_cls   = r_s1_dec.illegal ? IMM_CLS_I : r_s1_dec.cls;

    always_comb begin
        w_result = w_ext;
        if (r_s1_dec.illegal) begin
            w_result = '0;
        end else if (w_is_mov && r_s1_dec.keep && w_tag_hit) begin
            w_result = (r_acc & w_keep_mask) | w_ext;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            r_run      <= 1'b0;
            r_s1_valid <= 1'b0;
            r_s1_imm26 <= '0;
            r_s1_dec   <= '0;
        end else begin
            r_run <= 1'b1;
            if (w_accept) begin
                r_s1_valid <= 1'b1;
                r_s1_imm26 <= in_instr[25:0];
                r_s1_dec   <= w_dec;
            end else if (w_s1_adv) begin
                r_s1_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            r_out_valid <= 1'b0;
            r_out_imm   <= '0;
            r_out_cls   <= '0;
            r_out_ill   <= 1'b0;
        end else if (w_s2_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_imm <= w_result;
                r_out_cls <= w_out_cls;
                r_out_ill <= r_s1_dec.illegal;
            end
        end
    end

    // Updated on the S1->S2 edge so a following MOVK in S1 sees it next cycle.
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            r_acc      <= '0;
            r_acc_tag  <= '0;
            r_acc_live <= 1'b0;
        end else if (w_s1_adv && w_is_mov) begin
            r_acc      <= w_result;
            r_acc_tag  <= w_rd_tag;
            r_acc_live <= 1'b1;
        end
    end

    assign out_valid   = r_out_valid;
    assign out_imm     = r_out_imm;
    assign out_class   = r_out_cls;
    assign out_illegal = r_out_ill;

`ifdef IMM_STATS_EN
    logic [STAT_W-1:0] r_ext_cnt;
    logic [STAT_W-1:0] r_ill_cnt;

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            r_ext_cnt <= '0;
            r_ill_cnt <= '0;
        end else if (r_out_valid && out_ready) begin
            if (r_out_ill) begin
                if (r_ill_cnt != '1) r_ill_cnt <= r_ill_cnt + STAT_W'(1);
            end else begin
                if (r_ext_cnt != '1) r_ext_cnt <= r_ext_cnt + STAT_W'(1);
            end
        end
    end

    assign stat_ext_cnt = r_ext_cnt;
    assign stat_ill_cnt = r_ill_cnt;
`else
    assign stat_ext_cnt = '0;
    assign stat_ill_cnt = '0;
`endif

endmodule
